// File: rtl/axi_mem_slave.sv
// axi_mem_slave: single-port word memory behind an AXI-style burst slave.
// Read and write channels run as independent FSMs; the memory is never reset.
// Optional feature: define AXI_SLV_WRAP_EN to accept WRAP (2'b10) bursts.
module axi_mem_slave #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp
);
  localparam int NBYTES = DATA_W / 8;
  localparam int SZ_MAX = $clog2(NBYTES);
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
`ifdef AXI_SLV_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  r_state_t          r_state, r_next;
  w_state_t          w_state, w_next;
  logic              live;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [3:0]        r_len, r_cnt, w_len, w_cnt;
  logic [2:0]        r_size, w_size;
  logic [1:0]        r_burst, w_burst;
  logic              r_berr, w_berr, w_err;
  logic              ar_fire, r_fire, aw_fire, w_fire;
  logic              w_beat_err, mem_we;
  logic [DATA_W-1:0] w_mask;

  function automatic logic burst_bad(input logic [1:0] burst, input logic [3:0] len);
    logic len_ok;
    len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    case (burst)
      2'b00, 2'b01: burst_bad = 1'b0;
      2'b10:        burst_bad = !(WRAP_EN && len_ok);
      default:      burst_bad = 1'b1;
    endcase
  endfunction

  function automatic logic beat_bad(input logic [ADDR_W-1:0] addr, input logic [2:0] size);
    beat_bad = (int'(size) > SZ_MAX) || ({1'b0, addr} >= DEPTH_L);
  endfunction

  function automatic logic [DATA_W-1:0] size_mask(input logic [2:0] size);
    size_mask = '0;
    for (int unsigned i = 0; i < NBYTES; i++)
      size_mask[i*8 +: 8] = (i < (32'd1 << size)) ? 8'hFF : 8'h00;
  endfunction

  // WRAP keeps the upper address bits and wraps the low log2(len+1) bits.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [1:0] burst,
                                                  input logic [3:0] len);
    logic [ADDR_W-1:0] mask;
    mask = ADDR_W'(len);
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = WRAP_EN ? ((addr & ~mask) | ((addr + ADDR_W'(1)) & mask))
                                   : addr + ADDR_W'(1);
      default: next_addr = addr + ADDR_W'(1);
    endcase
  endfunction

  function automatic logic [IW-1:0] idx(input logic [ADDR_W-1:0] addr);
    idx = IW'(addr);
  endfunction

  // Returns {resp, data} for one read beat.
  function automatic logic [DATA_W+1:0] read_beat(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0] size,
                                                  input logic berr);
    if (berr || beat_bad(addr, size)) read_beat = {2'b10, {DATA_W{1'b0}}};
    else                              read_beat = {2'b00, mem[idx(addr)] & size_mask(size)};
  endfunction

  // Handshake readiness is held low until the first clock after reset release.
  always_ff @(posedge clk) begin
    live <= res_n;
  end

  // State registers for both channel FSMs.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = live;
        if (live && arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Write FSM next state, handshake outputs and burst response.
  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    case (w_state)
      W_IDLE: begin
        awready = live;
        if (live && awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && (w_cnt == 4'd0)) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = w_err ? 2'b10 : 2'b00;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  // Per-beat write qualification and byte-lane mask.
  always_comb begin
    w_beat_err = w_berr || beat_bad(w_addr, w_size);
    mem_we     = res_n && w_fire && !w_beat_err;
    w_mask     = size_mask(w_size);
  end

  // Read datapath: beat 0 is fetched on the AR handshake, later beats on each accepted beat.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_berr  <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
    end else if (ar_fire) begin
      r_addr           <= araddr;
      r_len            <= arlen;
      r_cnt            <= arlen;
      r_size           <= arsize;
      r_burst          <= arburst;
      r_berr           <= burst_bad(arburst, arlen);
      {rresp, rdata}   <= read_beat(araddr, arsize, burst_bad(arburst, arlen));
      rlast            <= (arlen == 4'd0);
    end else if (r_fire) begin
      if (rlast) begin
        rdata <= '0;
        rresp <= '0;
        rlast <= 1'b0;
      end else begin
        r_addr         <= next_addr(r_addr, r_burst, r_len);
        r_cnt          <= r_cnt - 4'd1;
        {rresp, rdata} <= read_beat(next_addr(r_addr, r_burst, r_len), r_size, r_berr);
        rlast          <= (r_cnt == 4'd1);
      end
    end
  end

  // Write datapath: address/count tracking and sticky burst error (incl. wlast misplacement).
  always_ff @(posedge clk) begin
    if (!res_n) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_berr  <= 1'b0;
      w_err   <= 1'b0;
    end else if (aw_fire) begin
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_cnt   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
      w_berr  <= burst_bad(awburst, awlen);
      w_err   <= 1'b0;
    end else if (w_fire) begin
      w_addr <= next_addr(w_addr, w_burst, w_len);
      w_cnt  <= w_cnt - 4'd1;
      w_err  <= w_err || w_beat_err || (wlast != (w_cnt == 4'd0));
    end
  end

  // Memory array: byte-masked write, no reset so contents survive res_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx(w_addr)] <= (mem[idx(w_addr)] & ~w_mask) | (wdata & w_mask);
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: randomized self-checking bench for axi_mem_slave (DATA_W=16, ADDR_W=6, DEPTH=32).
`timescale 1ns/1ps
module tb_axi_mem_slave;
  localparam int DW  = 16;
  localparam int AW  = 6;
  localparam int DEP = 32;
`ifdef AXI_SLV_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          res_n = 1'b0;
  logic          arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic [3:0]    arlen = '0;
  logic [2:0]    arsize = '0;
  logic [1:0]    arburst = '0;
  logic          rvalid, rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic [3:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic          wvalid = 1'b0, wready;
  logic [DW-1:0] wdata = '0;
  logic          wlast = 1'b0;
  logic          bvalid, bready = 1'b0;
  logic [1:0]    bresp;

  axi_mem_slave #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk(clk), .res_n(res_n),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference memory and transaction buffers.
  logic [15:0] mm [64];
  logic [15:0] wbuf [16];
  logic        wl [16];
  logic [15:0] rd_d [17];
  logic [1:0]  rd_r [17];
  logic        rd_l [17];
  int          rd_n;
  int          stall_bad;
  bit          first_ok, ar_back, bdrop;

  // ---------------- reference model ----------------
  function automatic int m_addr(int a, int len, int bu, int i);
    int n, base;
    n = len + 1;
    if (bu == 0) return a;
    if (bu == 2 && WRAP_EN) begin
      base = (a / n) * n;
      return base + (a - base + i) % n;
    end
    return (a + i) % 64;
  endfunction

  function automatic bit m_err(int ai, int len, int sz, int bu);
    int n;
    n = len + 1;
    if (bu == 3) return 1'b1;
    if (bu == 2 && !(WRAP_EN && (n == 2 || n == 4 || n == 8 || n == 16))) return 1'b1;
    if (sz > 1) return 1'b1;
    return ai >= DEP;
  endfunction

  function automatic logic [15:0] m_rd(int ai, int len, int sz, int bu);
    if (m_err(ai, len, sz, bu)) return 16'h0000;
    return (sz == 0) ? {8'h00, mm[ai][7:0]} : mm[ai];
  endfunction

  function automatic logic [1:0] m_wr_burst(int a, int len, int sz, int bu);
    bit e;
    e = 1'b0;
    for (int i = 0; i <= len; i++) begin
      int ai;
      ai = m_addr(a, len, bu, i);
      if (m_err(ai, len, sz, bu)) e = 1'b1;
      else if (sz == 0) mm[ai][7:0] = wbuf[i][7:0];
      else mm[ai] = wbuf[i];
      if (wl[i] != (i == len)) e = 1'b1;
    end
    return e ? 2'b10 : 2'b00;
  endfunction

  // ---------------- bus drivers (called at a negedge, return at a negedge) ----------------
  task automatic axi_write(input int a, input int len, input int sz, input int bu,
                           output logic [1:0] resp, output bit to);
    int n;
    to = 1'b0; bdrop = 1'b0; resp = 2'bxx;
    awaddr = AW'(a); awlen = 4'(len); awsize = 3'(sz); awburst = 2'(bu); awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1) begin @(negedge clk); n++; if (n > 50) begin to = 1'b1; break; end end
    @(negedge clk); awvalid = 1'b0;
    for (int i = 0; i <= len && !to; i++) begin
      if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk); end
      wdata = wbuf[i]; wlast = wl[i]; wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1) begin @(negedge clk); n++; if (n > 50) begin to = 1'b1; break; end end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!to && bvalid !== 1'b1) begin @(negedge clk); n++; if (n > 50) to = 1'b1; end
    if (to) return;
    repeat ($urandom_range(0, 2)) begin @(negedge clk); if (bvalid !== 1'b1) bdrop = 1'b1; end
    resp = bresp; bready = 1'b1;
    @(negedge clk); bready = 1'b0;
  endtask

  // mode: 0 rready always 1, 1 toggling 1,0,1,..., 2 random
  task automatic axi_read(input int a, input int len, input int sz, input int bu,
                          input int mode, output bit to);
    int n;
    bit have;
    logic [15:0] hd; logic [1:0] hr; logic hl;
    to = 1'b0; rd_n = 0; stall_bad = 0; first_ok = 1'b0; ar_back = 1'b0; have = 1'b0;
    hd = '0; hr = '0; hl = 1'b0;
    araddr = AW'(a); arlen = 4'(len); arsize = 3'(sz); arburst = 2'(bu); arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1) begin @(negedge clk); n++; if (n > 50) begin to = 1'b1; break; end end
    @(negedge clk); arvalid = 1'b0;
    if (to) return;
    first_ok = (rvalid === 1'b1);
    n = 0;
    while (!to) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (n % 2 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (rvalid === 1'b1) begin
        if (have && (rdata !== hd || rresp !== hr || rlast !== hl)) stall_bad++;
        if (rready) begin
          rd_d[rd_n] = rdata; rd_r[rd_n] = rresp; rd_l[rd_n] = rlast; rd_n++; have = 1'b0;
          if (rlast === 1'b1 || rd_n == 17) begin
            @(negedge clk); rready = 1'b0; ar_back = (arready === 1'b1);
            break;
          end
        end else begin
          have = 1'b1; hd = rdata; hr = rresp; hl = rlast;
        end
      end
      @(negedge clk); n++;
      if (n > 200) to = 1'b1;
    end
    rready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    res_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({arready, awready, rvalid, wready, bvalid, rlast, rdata, rresp, bresp} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ar=%b aw=%b rv=%b wr=%b bv=%b rl=%b rd=%h rr=%b br=%b required all 0",
               arready, awready, rvalid, wready, bvalid, rlast, rdata, rresp, bresp);
    end
    res_n = 1'b1;
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || awready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got ar=%b aw=%b required 1 1", arready, awready);
    end
  endtask

  task automatic test_init;
    logic [1:0] r; bit to;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 16; i++) begin wbuf[i] = 16'($urandom); wl[i] = (i == 15); end
      axi_write(b * 16, 15, 1, 1, r, to);
      checks++;
      if (to || r !== m_wr_burst(b * 16, 15, 1, 1)) begin
        failures++;
        $display("FAIL init_bresp burst=%0d got=%b required=00 timeout=%0d", b, r, to);
      end
    end
  endtask

  task automatic test_incr_write_read;
    logic [15:0] ex [4];
    logic [1:0] r; bit to;
    ex = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin wbuf[i] = ex[i]; wl[i] = (i == 3); end
    axi_write(2, 3, 1, 1, r, to);
    void'(m_wr_burst(2, 3, 1, 1));
    checks++;
    if (to || r !== 2'b00) begin
      failures++; $display("FAIL incr_bresp got=%b required=00 timeout=%0d", r, to);
    end
    axi_read(2, 3, 1, 1, 0, to);
    checks++;
    if (to || rd_n != 4 || !first_ok || !ar_back) begin
      failures++;
      $display("FAIL incr_read_shape beats=%0d required 4 first_rvalid=%0d arready_after=%0d timeout=%0d",
               rd_n, first_ok, ar_back, to);
    end
    for (int i = 0; i < 4 && i < rd_n; i++) begin
      checks++;
      if ({rd_d[i], rd_r[i], rd_l[i]} !== {ex[i], 2'b00, 1'(i == 3)}) begin
        failures++;
        $display("FAIL incr_read_beat%0d got d=%h r=%b l=%b required d=%h r=00 l=%0d",
                 i, rd_d[i], rd_r[i], rd_l[i], ex[i], i == 3);
      end
    end
  endtask

  task automatic test_fixed_stall;
    bit to;
    axi_read(5, 2, 1, 0, 1, to);
    checks++;
    if (to || rd_n != 3 || stall_bad != 0) begin
      failures++;
      $display("FAIL fixed_stall beats=%0d required 3 unstable=%0d required 0 timeout=%0d", rd_n, stall_bad, to);
    end
    for (int i = 0; i < 3 && i < rd_n; i++) begin
      checks++;
      if ({rd_d[i], rd_r[i], rd_l[i]} !== {mm[5], 2'b00, 1'(i == 2)}) begin
        failures++;
        $display("FAIL fixed_beat%0d got d=%h r=%b l=%b required d=%h r=00 l=%0d",
                 i, rd_d[i], rd_r[i], rd_l[i], mm[5], i == 2);
      end
    end
  endtask

  task automatic test_early_wlast;
    logic [1:0] r; bit to;
    wbuf[0] = 16'($urandom); wbuf[1] = 16'($urandom); wl[0] = 1'b1; wl[1] = 1'b0;
    axi_write(8, 1, 1, 1, r, to);
    void'(m_wr_burst(8, 1, 1, 1));
    checks++;
    if (to || r !== 2'b10 || bdrop) begin
      failures++; $display("FAIL early_wlast_bresp got=%b required=10 bvalid_dropped=%0d timeout=%0d", r, bdrop, to);
    end
    axi_read(8, 1, 1, 1, 0, to);
    checks++;
    if (to || rd_n != 2 || rd_d[0] !== wbuf[0] || rd_d[1] !== wbuf[1]) begin
      failures++;
      $display("FAIL early_wlast_data got %h %h required %h %h beats=%0d", rd_d[0], rd_d[1], wbuf[0], wbuf[1], rd_n);
    end
  endtask

  task automatic test_out_of_range;
    bit to;
    axi_read(30, 3, 1, 1, 0, to);
    checks++;
    if (to || rd_n != 4) begin failures++; $display("FAIL oor_beats got=%0d required=4 timeout=%0d", rd_n, to); end
    for (int i = 0; i < 4 && i < rd_n; i++) begin
      checks++;
      if ({rd_d[i], rd_r[i]} !== {(i < 2) ? mm[30 + i] : 16'h0000, (i < 2) ? 2'b00 : 2'b10}) begin
        failures++;
        $display("FAIL oor_beat%0d got d=%h r=%b", i, rd_d[i], rd_r[i]);
      end
    end
  endtask

  task automatic test_wrap;
    bit to;
    axi_read(6, 3, 1, 2, 0, to);
    checks++;
    if (to || rd_n != 4) begin failures++; $display("FAIL wrap_beats got=%0d required=4 timeout=%0d", rd_n, to); end
    for (int i = 0; i < 4 && i < rd_n; i++) begin
      int ai;
      ai = m_addr(6, 3, 2, i);
      checks++;
      if ({rd_d[i], rd_r[i]} !== {m_rd(ai, 3, 1, 2), m_err(ai, 3, 1, 2) ? 2'b10 : 2'b00}) begin
        failures++;
        $display("FAIL wrap_beat%0d got d=%h r=%b required d=%h", i, rd_d[i], rd_r[i], m_rd(ai, 3, 1, 2));
      end
    end
  endtask

  task automatic test_size;
    logic [1:0] r; bit to;
    wbuf[0] = 16'hABCD; wl[0] = 1'b1;
    axi_write(10, 0, 0, 1, r, to);
    void'(m_wr_burst(10, 0, 0, 1));
    checks++;
    if (to || r !== 2'b00) begin failures++; $display("FAIL size0_bresp got=%b required=00", r); end
    wbuf[0] = 16'h5A5A;
    axi_write(10, 0, 2, 1, r, to);
    void'(m_wr_burst(10, 0, 2, 1));
    checks++;
    if (to || r !== 2'b10) begin failures++; $display("FAIL size2_bresp got=%b required=10", r); end
    axi_read(10, 0, 1, 1, 0, to);
    checks++;
    if (to || rd_d[0] !== mm[10]) begin failures++; $display("FAIL size_full_read got=%h required=%h", rd_d[0], mm[10]); end
    axi_read(10, 0, 0, 1, 0, to);
    checks++;
    if (to || rd_d[0] !== 16'h00CD || rd_r[0] !== 2'b00) begin
      failures++; $display("FAIL size0_read got=%h r=%b required=00cd r=00", rd_d[0], rd_r[0]);
    end
  endtask

  task automatic test_same_word;
    logic [15:0] old, nw; bit to;
    old = mm[12]; nw = ~old;
    awaddr = AW'(12); awlen = 4'd0; awsize = 3'd1; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0;
    araddr = AW'(12); arlen = 4'd0; arsize = 3'd1; arburst = 2'b01; arvalid = 1'b1;
    wdata = nw; wlast = 1'b1; wvalid = 1'b1;
    @(negedge clk); arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== old || bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++;
      $display("FAIL same_word got rv=%b rd=%h bv=%b br=%b required rv=1 rd=%h bv=1 br=00", rvalid, rdata, bvalid, bresp, old);
    end
    rready = 1'b1; bready = 1'b1;
    @(negedge clk); rready = 1'b0; bready = 1'b0;
    mm[12] = nw;
    axi_read(12, 0, 1, 1, 0, to);
    checks++;
    if (to || rd_d[0] !== nw) begin failures++; $display("FAIL same_word_after got=%h required=%h", rd_d[0], nw); end
  endtask

  task automatic test_reset_mid;
    bit to;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 16'($urandom); wl[i] = (i == 3); end
    awaddr = AW'(20); awlen = 4'd3; awsize = 3'd1; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin wdata = wbuf[i]; wlast = 1'b0; wvalid = 1'b1; @(negedge clk); end
    res_n = 1'b0; wdata = wbuf[2];
    @(negedge clk);
    checks++;
    if ({arready, awready, rvalid, wready, bvalid, rlast, rdata, rresp, bresp} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got ar=%b aw=%b rv=%b wr=%b bv=%b required all 0", arready, awready, rvalid, wready, bvalid);
    end
    res_n = 1'b1; wvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (awready !== 1'b1 || arready !== 1'b1) begin
      failures++; $display("FAIL mid_reset_release got aw=%b ar=%b required 1 1", awready, arready);
    end
    mm[20] = wbuf[0]; mm[21] = wbuf[1];
    axi_read(20, 3, 1, 1, 0, to);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (to || rd_d[i] !== mm[20 + i]) begin
        failures++; $display("FAIL mid_reset_word%0d got=%h required=%h", 20 + i, rd_d[i], mm[20 + i]);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0] r, e; bit to;
    for (int t = 0; t < 40; t++) begin
      int a, len, sz, bu;
      a   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 31));
      len = $urandom_range(0, 15);
      sz  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 3)) : int'($urandom_range(0, 1));
      bu  = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin wbuf[i] = 16'($urandom); wl[i] = (i == len); end
        if ($urandom_range(0, 5) == 0) begin
          int k;
          k = $urandom_range(0, len);
          wl[k] = ~wl[k];
        end
        axi_write(a, len, sz, bu, r, to);
        e = m_wr_burst(a, len, sz, bu);
        checks++;
        if (to || r !== e || bdrop) begin
          failures++;
          $display("FAIL rand_write t=%0d a=%0d len=%0d sz=%0d bu=%0d got=%b required=%b timeout=%0d", t, a, len, sz, bu, r, e, to);
        end
      end else begin
        axi_read(a, len, sz, bu, 2, to);
        checks++;
        if (to || rd_n != len + 1 || stall_bad != 0 || !first_ok) begin
          failures++;
          $display("FAIL rand_read_shape t=%0d beats=%0d required=%0d unstable=%0d first=%0d timeout=%0d",
                   t, rd_n, len + 1, stall_bad, first_ok, to);
        end
        for (int i = 0; i <= len && i < rd_n; i++) begin
          int ai;
          ai = m_addr(a, len, bu, i);
          checks++;
          if ({rd_d[i], rd_r[i], rd_l[i]} !== {m_rd(ai, len, sz, bu), m_err(ai, len, sz, bu) ? 2'b10 : 2'b00, 1'(i == len)}) begin
            failures++;
            $display("FAIL rand_read t=%0d beat=%0d addr=%0d got d=%h r=%b l=%b required d=%h",
                     t, i, ai, rd_d[i], rd_r[i], rd_l[i], m_rd(ai, len, sz, bu));
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init();
    test_incr_write_read();
    test_fixed_stall();
    test_early_wlast();
    test_out_of_range();
    test_wrap();
    test_size();
    test_same_word();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
